// File: rtl/health_test_mc.sv
// health_test_mc
// Online health monitor for NCH raw TRNG bit streams. Each channel runs a
// repetition count test (RCT) on run lengths and an adaptive proportion test
// (APT) over a shared window of W = 2^LOG2_WIN samples. A channel's alarm is
// set after FAIL_THRESH consecutive enabled samples with an error and stays
// set until clear_alarm or reset. A small FSM qualifies the source at startup
// and whenever clear_alarm is pulsed.
//
// Parameter constraints: W/2 <= APT_CUTOFF < W, RCT_CUTOFF >= 2,
// FAIL_THRESH >= 1, STARTUP_WIN >= 1.
module health_test_mc #(
    parameter int NCH         = 4,
    parameter int LOG2_WIN    = 10,
    parameter int APT_CUTOFF  = 589,
    parameter int RCT_CUTOFF  = 28,
    parameter int FAIL_THRESH = 11,
    parameter int STARTUP_WIN = 2
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         enable,
    input  logic [NCH-1:0]               rnd_bits,
    input  logic                         clear_alarm,
    output logic [NCH-1:0]               error,
    output logic [NCH-1:0]               alarm,
    output logic                         any_alarm,
    output logic                         startup_done,
    output logic                         win_done,
    output logic [NCH*(LOG2_WIN+1)-1:0]  ones_count
);

    // Counter widths
    localparam int AW = LOG2_WIN + 1;
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int CW = $clog2(FAIL_THRESH + 1);
    localparam int PW = $clog2(STARTUP_WIN + 1);

    // Sized constants so every compare and increment is width-exact
    localparam logic [LOG2_WIN-1:0] CNT_LAST   = {LOG2_WIN{1'b1}};
    localparam logic [LOG2_WIN-1:0] CNT_ONE    = LOG2_WIN'(1);
    localparam logic [AW-1:0]       APT_HI     = AW'(APT_CUTOFF);
    localparam logic [AW-1:0]       APT_LO     = AW'((2 ** LOG2_WIN) - APT_CUTOFF);
    localparam logic [RW-1:0]       RUN_MAX    = RW'(RCT_CUTOFF);
    localparam logic [RW-1:0]       RUN_ONE    = RW'(1);
    localparam logic [CW-1:0]       CONSEC_MAX = CW'(FAIL_THRESH);
    localparam logic [CW-1:0]       CONSEC_PRE = CW'(FAIL_THRESH - 1);
    localparam logic [CW-1:0]       CONSEC_ONE = CW'(1);
    localparam logic [PW-1:0]       PASS_MAX   = PW'(STARTUP_WIN);
    localparam logic [PW-1:0]       PASS_PRE   = PW'(STARTUP_WIN - 1);
    localparam logic [PW-1:0]       PASS_ONE   = PW'(1);

    typedef enum logic [0:0] {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    // RCT state
    logic                have_prev;
    logic [NCH-1:0]      prev_bit;
    logic [RW-1:0]       run      [NCH];
    logic [RW-1:0]       run_next [NCH];
    logic [NCH-1:0]      rct_fail;

    // APT state
    logic [LOG2_WIN-1:0] cnt;
    logic                win_last;
    logic [AW-1:0]       acc       [NCH];
    logic [AW-1:0]       win_final [NCH];
    logic [NCH-1:0]      apt_fail;

    // Alarm state
    logic [CW-1:0]       consec [NCH];

    // Startup qualification state
    state_t              state;
    logic [PW-1:0]       pass_cnt;
    logic                window_ok;

    assign win_last  = (cnt == CNT_LAST);
    assign error     = rct_fail | apt_fail;
    assign any_alarm = |alarm;
    assign window_ok = ~(|apt_fail) & ~(|rct_fail) & ~any_alarm;

    // Next run length and window total for the sample currently presented
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            run_next[i]  = RUN_ONE;
            win_final[i] = acc[i] + {{(AW-1){1'b0}}, rnd_bits[i]};
            if (have_prev && (rnd_bits[i] == prev_bit[i])) begin
                run_next[i] = (run[i] == RUN_MAX) ? RUN_MAX : (run[i] + RUN_ONE);
            end
        end
    end

    // Repetition count test: track run length per channel and flag long runs
    always_ff @(posedge clk) begin
        if (rst_i) begin
            have_prev <= 1'b0;
            prev_bit  <= '0;
            rct_fail  <= '0;
            for (int i = 0; i < NCH; i++) begin
                run[i] <= '0;
            end
        end else if (enable) begin
            have_prev <= 1'b1;
            prev_bit  <= rnd_bits;
            for (int i = 0; i < NCH; i++) begin
                run[i]      <= run_next[i];
                rct_fail[i] <= (run_next[i] >= RUN_MAX);
            end
        end
    end

    // Adaptive proportion test: count ones over a window, judge on the last sample
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt        <= '0;
            apt_fail   <= '0;
            ones_count <= '0;
            win_done   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            win_done <= enable && win_last;
            if (enable) begin
                if (win_last) begin
                    cnt <= '0;
                    for (int i = 0; i < NCH; i++) begin
                        acc[i]                  <= '0;
                        ones_count[i*AW +: AW]  <= win_final[i];
                        apt_fail[i]             <= (win_final[i] > APT_HI) ||
                                                   (win_final[i] < APT_LO);
                    end
                end else begin
                    cnt <= cnt + CNT_ONE;
                    for (int i = 0; i < NCH; i++) begin
                        acc[i] <= win_final[i];
                    end
                end
            end
        end
    end

    // Consecutive-error counter per channel driving the sticky alarm
    always_ff @(posedge clk) begin
        if (rst_i) begin
            alarm <= '0;
            for (int i = 0; i < NCH; i++) begin
                consec[i] <= '0;
            end
        end else if (clear_alarm) begin
            alarm <= '0;
            for (int i = 0; i < NCH; i++) begin
                consec[i] <= '0;
            end
        end else if (enable) begin
            for (int i = 0; i < NCH; i++) begin
                if (error[i]) begin
                    if (consec[i] == CONSEC_PRE) begin
                        alarm[i] <= 1'b1;
                    end
                    consec[i] <= (consec[i] == CONSEC_MAX) ? CONSEC_MAX
                                                           : (consec[i] + CONSEC_ONE);
                end else begin
                    consec[i] <= '0;
                end
            end
        end
    end

    // Startup qualification FSM: needs STARTUP_WIN clean windows in a row
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state        <= ST_STARTUP;
            pass_cnt     <= '0;
            startup_done <= 1'b0;
        end else if (clear_alarm) begin
            state        <= ST_STARTUP;
            pass_cnt     <= '0;
            startup_done <= 1'b0;
        end else if (win_done) begin
            case (state)
                ST_STARTUP: begin
                    if (window_ok) begin
                        if (pass_cnt == PASS_PRE) begin
                            state        <= ST_RUN;
                            startup_done <= 1'b1;
                        end
                        pass_cnt <= (pass_cnt == PASS_MAX) ? PASS_MAX
                                                           : (pass_cnt + PASS_ONE);
                    end else begin
                        pass_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    startup_done <= 1'b1;
                end
                default: begin
                    state        <= ST_STARTUP;
                    pass_cnt     <= '0;
                    startup_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_health_test_mc.sv
// Directed testbench for health_test_mc with a small configuration (W=16).
module tb_health_test_mc;

    localparam int NCH         = 2;
    localparam int LOG2_WIN    = 4;
    localparam int APT_CUTOFF  = 12;
    localparam int RCT_CUTOFF  = 6;
    localparam int FAIL_THRESH = 3;
    localparam int STARTUP_WIN = 2;
    localparam int AW          = LOG2_WIN + 1;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                enable;
    logic [NCH-1:0]      rnd_bits;
    logic                clear_alarm;
    logic [NCH-1:0]      error;
    logic [NCH-1:0]      alarm;
    logic                any_alarm;
    logic                startup_done;
    logic                win_done;
    logic [NCH*AW-1:0]   ones_count;

    int assertCount = 0;
    int failCount   = 0;

    // Bit patterns, first sample in the MSB
    logic [15:0] patAlt    = 16'h5555;
    logic [15:0] patOnes   = 16'hFFFF;
    logic [15:0] pat13     = 16'hF7BD;
    logic [15:0] pat12     = 16'hEEEE;
    logic [15:0] pat4      = 16'h1111;
    logic [15:0] pat3      = 16'h0411;

    always #5 clk = ~clk;

    health_test_mc #(
        .NCH(NCH), .LOG2_WIN(LOG2_WIN), .APT_CUTOFF(APT_CUTOFF),
        .RCT_CUTOFF(RCT_CUTOFF), .FAIL_THRESH(FAIL_THRESH), .STARTUP_WIN(STARTUP_WIN)
    ) dut (
        .clk(clk),
        .rst_i(rst_i),
        .enable(enable),
        .rnd_bits(rnd_bits),
        .clear_alarm(clear_alarm),
        .error(error),
        .alarm(alarm),
        .any_alarm(any_alarm),
        .startup_done(startup_done),
        .win_done(win_done),
        .ones_count(ones_count)
    );

    // Sample k (1-based) of a periodic 16-sample pattern
    function automatic logic patBit(input logic [15:0] p, input int k);
        return p[15 - ((k - 1) % 16)];
    endfunction

    // Expected packed ones_count for channel 1 / channel 0 totals
    function automatic logic [31:0] packOnes(input int c1, input int c0);
        return 32'((c1 << AW) | c0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs and return #1 after the sampling edge
    task automatic applyStimulus(input logic en, input logic [NCH-1:0] bits,
                                 input logic clr);
        enable      = en;
        rnd_bits    = bits;
        clear_alarm = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        rst_i = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " error"}, 32'(error), 32'd0);
        checkOutput({tag, " alarm"}, 32'(alarm), 32'd0);
        checkOutput({tag, " any_alarm"}, 32'(any_alarm), 32'd0);
        checkOutput({tag, " startup_done"}, 32'(startup_done), 32'd0);
        checkOutput({tag, " win_done"}, 32'(win_done), 32'd0);
        checkOutput({tag, " ones_count"}, 32'(ones_count), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        enable      = 1'b0;
        rnd_bits    = '0;
        clear_alarm = 1'b0;

        // Reset state
        doReset();
        checkAllZero("reset");

        // Scenario 1: alternating data qualifies the source, then clear_alarm drops it
        $display("[TB] alternating stream");
        for (int k = 1; k <= 34; k++) begin
            applyStimulus(1'b1, {patBit(patAlt, k), patBit(patAlt, k)}, (k == 34));
            checkOutput($sformatf("s1 error k=%0d", k), 32'(error), 32'd0);
            if (k == 15 || k == 17)
                checkOutput($sformatf("s1 win_done k=%0d", k), 32'(win_done), 32'd0);
            if (k == 16 || k == 32) begin
                checkOutput($sformatf("s1 win_done k=%0d", k), 32'(win_done), 32'd1);
                checkOutput($sformatf("s1 ones k=%0d", k), 32'(ones_count), packOnes(8, 8));
            end
            if (k == 17 || k == 32 || k == 34)
                checkOutput($sformatf("s1 startup_done k=%0d", k), 32'(startup_done), 32'd0);
            if (k == 33)
                checkOutput("s1 startup_done k=33", 32'(startup_done), 32'd1);
        end

        // Scenario 2 + 6: stuck channel 0 raises alarm; clear_alarm and requalify
        $display("[TB] stuck channel and clear");
        doReset();
        for (int k = 1; k <= 65; k++) begin
            if (k <= 16)
                applyStimulus(1'b1, {patBit(patAlt, k), patBit(patOnes, k)}, 1'b0);
            else
                applyStimulus(1'b1, {patBit(patAlt, k), patBit(patAlt, k)}, (k == 34));
            if (k == 5)
                checkOutput("s2 error k=5", 32'(error), 32'd0);
            if (k == 6)
                checkOutput("s2 error k=6", 32'(error), 32'd1);
            if (k == 8)
                checkOutput("s2 alarm k=8", 32'(alarm), 32'd0);
            if (k == 9) begin
                checkOutput("s2 alarm k=9", 32'(alarm), 32'd1);
                checkOutput("s2 any_alarm k=9", 32'(any_alarm), 32'd1);
            end
            if (k == 16) begin
                checkOutput("s2 ones k=16", 32'(ones_count), packOnes(8, 16));
                checkOutput("s2 error k=16", 32'(error), 32'd1);
            end
            if (k == 32) begin
                checkOutput("s2 error k=32", 32'(error), 32'd0);
                checkOutput("s2 alarm sticky k=32", 32'(alarm), 32'd1);
            end
            if (k == 34) begin
                checkOutput("s6 alarm after clear", 32'(alarm), 32'd0);
                checkOutput("s6 any_alarm after clear", 32'(any_alarm), 32'd0);
                checkOutput("s6 startup_done after clear", 32'(startup_done), 32'd0);
            end
            if (k == 64)
                checkOutput("s6 startup_done k=64", 32'(startup_done), 32'd0);
            if (k == 65) begin
                checkOutput("s6 startup_done k=65", 32'(startup_done), 32'd1);
                checkOutput("s6 alarm k=65", 32'(alarm), 32'd0);
            end
        end

        // Scenario 6: reset mid-window at cnt=7 discards the partial window
        $display("[TB] mid-window reset");
        doReset();
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 2'b01, 1'b0);
            if (k == 6)
                checkOutput("s6r error k=6", 32'(error), 32'd3);
        end
        rst_i = 1'b1;
        applyStimulus(1'b1, 2'b01, 1'b0);
        rst_i = 1'b0;
        checkAllZero("s6r after reset");
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, {patBit(patAlt, k), patBit(patAlt, k)}, 1'b0);
            if (k == 9)
                checkOutput("s6r win_done k=9", 32'(win_done), 32'd0);
            if (k == 16) begin
                checkOutput("s6r win_done k=16", 32'(win_done), 32'd1);
                checkOutput("s6r ones k=16", 32'(ones_count), packOnes(8, 8));
                checkOutput("s6r error k=16", 32'(error), 32'd0);
            end
        end

        // Scenario 3: 13 ones with short runs fails APT only
        $display("[TB] APT high failure");
        doReset();
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(1'b1, {patBit(patAlt, k), patBit(pat13, k)}, 1'b0);
            if (k <= 15)
                checkOutput($sformatf("s3 error k=%0d", k), 32'(error), 32'd0);
            if (k == 16) begin
                checkOutput("s3 error k=16", 32'(error), 32'd1);
                checkOutput("s3 ones k=16", 32'(ones_count), packOnes(8, 13));
            end
            if (k == 18)
                checkOutput("s3 alarm k=18", 32'(alarm), 32'd0);
            if (k == 19)
                checkOutput("s3 alarm k=19", 32'(alarm), 32'd1);
        end

        // Scenario 4: APT boundaries, 12/4 pass and 13/3 fail
        $display("[TB] APT boundaries");
        doReset();
        for (int k = 1; k <= 32; k++) begin
            if (k <= 16)
                applyStimulus(1'b1, {patBit(pat4, k), patBit(pat12, k)}, 1'b0);
            else
                applyStimulus(1'b1, {patBit(pat3, k), patBit(pat13, k)}, 1'b0);
            if (k == 16) begin
                checkOutput("s4 error k=16", 32'(error), 32'd0);
                checkOutput("s4 ones k=16", 32'(ones_count), packOnes(4, 12));
            end
            if (k == 31)
                checkOutput("s4 error k=31", 32'(error), 32'd0);
            if (k == 32) begin
                checkOutput("s4 error k=32", 32'(error), 32'd3);
                checkOutput("s4 ones k=32", 32'(ones_count), packOnes(3, 13));
            end
        end

        // Scenario 5: enable pattern 1,0,0 gives the same result as contiguous data
        $display("[TB] gapped enable");
        doReset();
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b1, {patBit(patAlt, k), patBit(patAlt, k)}, 1'b0);
            checkOutput($sformatf("s5 win_done k=%0d", k), 32'(win_done),
                        32'((k % 16) == 0));
            checkOutput($sformatf("s5 error k=%0d", k), 32'(error), 32'd0);
            if (k == 16 || k == 32)
                checkOutput($sformatf("s5 ones k=%0d", k), 32'(ones_count), packOnes(8, 8));
            if (k == 32)
                checkOutput("s5 startup_done k=32", 32'(startup_done), 32'd0);
            applyStimulus(1'b0, 2'b11, 1'b0);
            checkOutput($sformatf("s5 win_done gap k=%0d", k), 32'(win_done), 32'd0);
            if (k == 32)
                checkOutput("s5 startup_done gap k=32", 32'(startup_done), 32'd1);
            applyStimulus(1'b0, 2'b11, 1'b0);
        end
        checkOutput("s5 error end", 32'(error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
